// File: rtl/centroid_divider.sv
// K-means centroid update: divides three colour sums by a member count with one shared
// restoring divider. Optional round-to-nearest build: define CENTROID_ROUND_EN.
module centroid_divider #(
    parameter int SumWidth   = 26,
    parameter int CountWidth = 14,
    parameter int PixelWidth = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SumWidth-1:0]   red_sum,
    input  logic [SumWidth-1:0]   green_sum,
    input  logic [SumWidth-1:0]   blue_sum,
    input  logic [CountWidth-1:0] co_sum,
    output logic                  done,
    output logic                  empty,
    output logic [PixelWidth-1:0] red,
    output logic [PixelWidth-1:0] green,
    output logic [PixelWidth-1:0] blue
);

`ifdef CENTROID_ROUND_EN
    localparam int DivWidth = SumWidth + 1;
`else
    localparam int DivWidth = SumWidth;
`endif
    localparam int BitW = $clog2(DivWidth);
    localparam logic [BitW-1:0] BitTop = BitW'(DivWidth - 1);
    localparam logic [BitW-1:0] BitOne = BitW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Channel 3 is the commit slot: staged quotients move to the outputs as DONE is entered.
    localparam logic [1:0] ChRed    = 2'd0;
    localparam logic [1:0] ChGreen  = 2'd1;
    localparam logic [1:0] ChBlue   = 2'd2;
    localparam logic [1:0] ChCommit = 2'd3;

    state_t                state_r;
    state_t                state_n;
    logic [1:0]            ch_r;
    logic [BitW-1:0]       bit_r;
    logic [CountWidth-1:0] divisor_r;
    logic [CountWidth:0]   rem_r;
    logic [DivWidth-1:0]   quo_r;
    logic [DivWidth-1:0]   div_red_r;
    logic [DivWidth-1:0]   div_green_r;
    logic [DivWidth-1:0]   div_blue_r;
    logic [PixelWidth-1:0] stage_red_r;
    logic [PixelWidth-1:0] stage_green_r;
    logic [PixelWidth-1:0] stage_blue_r;
    logic [PixelWidth-1:0] red_r;
    logic [PixelWidth-1:0] green_r;
    logic [PixelWidth-1:0] blue_r;
    logic                  empty_r;
    logic                  done_r;
    logic                  in_ready_r;

    logic                  transfer_s;
    logic                  count_zero_s;
    logic [DivWidth-1:0]   cur_div_s;
    logic                  msb_s;
    logic [CountWidth:0]   rem_shift_s;
    logic                  ge_s;
    logic [CountWidth:0]   rem_next_s;
    logic [DivWidth-1:0]   quo_next_s;
    logic [PixelWidth-1:0] sat_s;
    logic                  last_bit_s;
    logic                  stepping_s;

    assign transfer_s   = in_valid && in_ready_r;
    assign count_zero_s = (co_sum == {CountWidth{1'b0}});
    assign stepping_s   = (state_r == ST_DIV) && (ch_r != ChCommit);
    assign last_bit_s   = (bit_r == {BitW{1'b0}});

    // Select the dividend of the channel being divided.
    always_comb begin
        cur_div_s = div_red_r;
        case (ch_r)
            ChRed:   cur_div_s = div_red_r;
            ChGreen: cur_div_s = div_green_r;
            ChBlue:  cur_div_s = div_blue_r;
            default: cur_div_s = div_red_r;
        endcase
    end

    // One restoring step plus saturation of the quotient that step would complete.
    always_comb begin
        msb_s       = cur_div_s[bit_r];
        rem_shift_s = {rem_r[CountWidth-1:0], msb_s};
        ge_s        = (rem_shift_s >= {1'b0, divisor_r});
        if (ge_s) begin
            rem_next_s = rem_shift_s - {1'b0, divisor_r};
        end else begin
            rem_next_s = rem_shift_s;
        end
        quo_next_s = {quo_r[DivWidth-2:0], ge_s};
        if (|quo_next_s[DivWidth-1:PixelWidth]) begin
            sat_s = {PixelWidth{1'b1}};
        end else begin
            sat_s = quo_next_s[PixelWidth-1:0];
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (transfer_s) begin
                    if (count_zero_s) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_DIV;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (ch_r == ChCommit) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_DIV;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // State register plus registered handshake/pulse outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            done_r     <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_n;
            done_r     <= (state_n == ST_DONE);
            in_ready_r <= (state_n == ST_IDLE);
        end
    end

    // Operand capture and the bit-serial divide walk across R, G, B.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch_r          <= ChRed;
            bit_r         <= {BitW{1'b0}};
            divisor_r     <= {CountWidth{1'b0}};
            rem_r         <= {(CountWidth+1){1'b0}};
            quo_r         <= {DivWidth{1'b0}};
            div_red_r     <= {DivWidth{1'b0}};
            div_green_r   <= {DivWidth{1'b0}};
            div_blue_r    <= {DivWidth{1'b0}};
            stage_red_r   <= {PixelWidth{1'b0}};
            stage_green_r <= {PixelWidth{1'b0}};
            stage_blue_r  <= {PixelWidth{1'b0}};
        end else if ((state_r == ST_IDLE) && transfer_s) begin
            ch_r      <= ChRed;
            bit_r     <= BitTop;
            divisor_r <= co_sum;
            rem_r     <= {(CountWidth+1){1'b0}};
            quo_r     <= {DivWidth{1'b0}};
`ifdef CENTROID_ROUND_EN
            // Adding half the divisor turns the truncating divide into round-to-nearest.
            div_red_r   <= {1'b0, red_sum}   + DivWidth'(co_sum >> 1);
            div_green_r <= {1'b0, green_sum} + DivWidth'(co_sum >> 1);
            div_blue_r  <= {1'b0, blue_sum}  + DivWidth'(co_sum >> 1);
`else
            div_red_r   <= red_sum;
            div_green_r <= green_sum;
            div_blue_r  <= blue_sum;
`endif
        end else if (stepping_s) begin
            if (last_bit_s) begin
                case (ch_r)
                    ChRed:   stage_red_r   <= sat_s;
                    ChGreen: stage_green_r <= sat_s;
                    ChBlue:  stage_blue_r  <= sat_s;
                    default: stage_red_r   <= stage_red_r;
                endcase
                ch_r  <= ch_r + 2'd1;
                bit_r <= BitTop;
                rem_r <= {(CountWidth+1){1'b0}};
                quo_r <= {DivWidth{1'b0}};
            end else begin
                bit_r <= bit_r - BitOne;
                rem_r <= rem_next_s;
                quo_r <= quo_next_s;
            end
        end else begin
            ch_r  <= ch_r;
            bit_r <= bit_r;
        end
    end

    // Result registers: touched only on the edge that enters DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            red_r   <= {PixelWidth{1'b0}};
            green_r <= {PixelWidth{1'b0}};
            blue_r  <= {PixelWidth{1'b0}};
            empty_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && transfer_s && count_zero_s) begin
            empty_r <= 1'b1;
        end else if ((state_r == ST_DIV) && (ch_r == ChCommit)) begin
            red_r   <= stage_red_r;
            green_r <= stage_green_r;
            blue_r  <= stage_blue_r;
            empty_r <= 1'b0;
        end else begin
            empty_r <= empty_r;
        end
    end

    assign in_ready = in_ready_r;
    assign done     = done_r;
    assign empty    = empty_r;
    assign red      = red_r;
    assign green    = green_r;
    assign blue     = blue_r;

endmodule

// File: tb/tb_centroid_divider.sv
// Randomised self-checking bench for centroid_divider against a transaction-level model.
module tb_centroid_divider;
    localparam int SW = 26;
    localparam int CW = 14;
    localparam int PW = 8;
`ifdef CENTROID_ROUND_EN
    localparam int LAT = 3 * (SW + 1) + 1;
    localparam int ROUND = 1;
`else
    localparam int LAT = 3 * SW + 1;
    localparam int ROUND = 0;
`endif

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] red_sum;
    logic [SW-1:0] green_sum;
    logic [SW-1:0] blue_sum;
    logic [CW-1:0] co_sum;
    logic          done;
    logic          empty;
    logic [PW-1:0] red;
    logic [PW-1:0] green;
    logic [PW-1:0] blue;

    centroid_divider #(.SumWidth(SW), .CountWidth(CW), .PixelWidth(PW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .red_sum(red_sum), .green_sum(green_sum), .blue_sum(blue_sum), .co_sum(co_sum),
        .done(done), .empty(empty), .red(red), .green(green), .blue(blue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Plain-arithmetic centroid of one channel.
    function automatic logic [7:0] ref_div(input longint sum, input longint cnt);
        longint q;
        q = (ROUND != 0) ? (sum + cnt / 2) / cnt : sum / cnt;
        return (q > 255) ? 8'd255 : q[7:0];
    endfunction

    // Transaction-level model: a transfer either completes immediately (empty) or after LAT edges.
    logic       m_ready, m_done, m_empty;
    logic [7:0] m_r, m_g, m_b, p_r, p_g, p_b;
    int         m_cnt;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ready <= 1'b1; m_done <= 1'b0; m_empty <= 1'b0;
            m_r <= 8'd0; m_g <= 8'd0; m_b <= 8'd0; m_cnt <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
            m_ready <= 1'b1;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_done <= 1'b1; m_empty <= 1'b0;
                m_r <= p_r; m_g <= p_g; m_b <= p_b;
            end
        end else if (m_ready && in_valid) begin
            m_ready <= 1'b0;
            if (co_sum == 14'd0) begin
                m_done <= 1'b1;
                m_empty <= 1'b1;
            end else begin
                p_r <= ref_div(longint'(red_sum), longint'(co_sum));
                p_g <= ref_div(longint'(green_sum), longint'(co_sum));
                p_b <= ref_div(longint'(blue_sum), longint'(co_sum));
                m_cnt <= LAT;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("in_ready", 64'(in_ready), 64'(m_ready));
            check("done", 64'(done), 64'(m_done));
            check("empty", 64'(empty), 64'(m_empty));
            check("red", 64'(red), 64'(m_r));
            check("green", 64'(green), 64'(m_g));
            check("blue", 64'(blue), 64'(m_b));
        end
    end

    task automatic rand_sums();
        red_sum = SW'($urandom);
        green_sum = SW'($urandom);
        blue_sum = SW'($urandom);
        co_sum = CW'($urandom);
    endtask

    // One transaction; returns edges from transfer to the start of the done cycle (-1 on timeout).
    task automatic xfer(input int r, input int g, input int b, input int c, input bit hold,
                        output int lat);
        @(negedge clk);
        red_sum = SW'(r); green_sum = SW'(g); blue_sum = SW'(b); co_sum = CW'(c);
        in_valid = 1'b1;
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
        rand_sums();
        lat = -1;
        for (int n = 0; n < LAT + 20; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            @(negedge clk);
            if (hold) rand_sums();
        end
        in_valid = 1'b0;
        if (lat < 0) check("done_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int c;
        bit saw;
        reset = 1'b0;
        in_valid = 1'b0;
        red_sum = '0; green_sum = '0; blue_sum = '0; co_sum = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rgb", 64'({red, green, blue, 7'd0, empty}), 64'd0);
        reset = 1'b1;
        cmp_en = 1'b1;

        // Nominal
        xfer(4, 8, 12, 4, 1'b0, lat);
        check("nom_latency", 64'(lat), 64'(LAT));
        check("nom_red", 64'(red), 64'd1);
        check("nom_green", 64'(green), 64'd2);
        check("nom_blue", 64'(blue), 64'd3);
        check("nom_empty", 64'(empty), 64'd0);

        // Empty cluster keeps previous centroid
        xfer(1234, 99, 7, 0, 1'b0, lat);
        check("empty_latency", 64'(lat), 64'd0);
        check("empty_flag", 64'(empty), 64'd1);
        check("empty_rgb", 64'({red, green, blue}), 64'({8'd1, 8'd2, 8'd3}));

        // Rounding
        xfer(10, 0, 0, 4, 1'b0, lat);
        check("round_red", 64'(red), (ROUND != 0) ? 64'd3 : 64'd2);
        check("round_empty", 64'(empty), 64'd0);

        // Saturation, including the 256 boundary
        xfer(1000, 256, 255, 1, 1'b0, lat);
        check("sat_red", 64'(red), 64'd255);
        check("sat_green", 64'(green), 64'd255);
        check("sat_blue", 64'(blue), 64'd255);

        // Busy rejection: in_valid held with changing sums
        xfer(40, 80, 120, 40, 1'b1, lat);
        check("busy_latency", 64'(lat), 64'(LAT));
        check("busy_rgb", 64'({red, green, blue}), 64'({8'd1, 8'd2, 8'd3}));

        // Reset 20 cycles into the division
        @(negedge clk);
        red_sum = 26'd400; green_sum = 26'd800; blue_sum = 26'd1200; co_sum = 14'd4;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_rgb", 64'({red, green, blue}), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        #1 reset = 1'b1;
        saw = 1'b0;
        for (int n = 0; n < LAT + 5; n++) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        check("abort_no_done", 64'(saw), 64'd0);
        check("abort_ready_after", 64'(in_ready), 64'd1);
        xfer(4, 8, 12, 4, 1'b0, lat);
        check("post_rst_rgb", 64'({red, green, blue}), 64'({8'd1, 8'd2, 8'd3}));

        // Randomised transactions
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0: c = 0;
                1: c = $urandom_range(1, 15);
                2: c = $urandom_range(1, 16383);
                default: c = $urandom_range(1, 300);
            endcase
            if ($urandom_range(0, 1) == 0)
                xfer($urandom_range(0, c * 256), $urandom_range(0, c * 256),
                     $urandom_range(0, c * 256), c, 1'($urandom), lat);
            else
                xfer(int'($urandom & 32'h03FF_FFFF), int'($urandom & 32'h03FF_FFFF),
                     int'($urandom & 32'h03FF_FFFF), c, 1'($urandom), lat);
            check("rand_latency", 64'(lat), (c == 0) ? 64'd0 : 64'(LAT));
        end

        repeat (3) @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
